// File: rtl/mem_access_stage.sv
// mem_access_stage: registers EX results toward WB, runs load/store memory transactions, drives EX forwarding.
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        wreg_i,
  input  logic [63:0] wdata_i,
  input  logic [63:0] store_data_i,
  input  logic [11:0] csr_waddr_i,
  input  logic        csr_wreg_i,
  input  logic [63:0] csr_wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [7:0]  dmem_wmask_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic        wb_wreg_o,
  output logic [63:0] wb_wdata_o,
  output logic [11:0] wb_csr_waddr_o,
  output logic        wb_csr_wreg_o,
  output logic [63:0] wb_csr_wdata_o,
  output logic [4:0]  mem_back_rd_addr_o,
  output logic        mem_back_wreg_o,
  output logic [63:0] mem_back_wdata_o,
  output logic [11:0] mem_back_csr_waddr_o,
  output logic        mem_back_csr_wreg_o,
  output logic [63:0] mem_back_csr_wdata_o,
  output logic        stall_req_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  localparam logic [6:0]  OP_LD = 7'b0000011;
  localparam logic [6:0]  OP_ST = 7'b0100011;
  localparam logic [31:0] TO = 32'(TIMEOUT_CYCLES);
  state_t state, state_nx;
  logic [31:0] cnt;
  logic        cap_load, cap_wreg, cap_csr_wreg;
  logic [2:0]  cap_f3;
  logic [4:0]  cap_rd;
  logic [11:0] cap_csr_waddr;
  logic [63:0] cap_wdata, cap_csr_wdata;
  logic        acc, is_ld, is_st, is_mem, misal, tmo, done_st, done_ld, abort, fin;
  logic [7:0]  sz_mask;
  logic [63:0] st_rep, lane, ld_data;
  always_comb begin
    acc     = ex_valid_i & ex_ready_o;
    is_ld   = opcode_i == OP_LD;
    is_st   = opcode_i == OP_ST;
    is_mem  = is_ld | is_st;
    misal   = |(wdata_i[2:0] & {funct3_i[1:0] == 2'd3, funct3_i[1], |funct3_i[1:0]});
    sz_mask = funct3_i[1:0] == 2'd0 ? 8'h01 : funct3_i[1:0] == 2'd1 ? 8'h03 :
              funct3_i[1:0] == 2'd2 ? 8'h0F : 8'hFF;
    st_rep  = funct3_i[1:0] == 2'd0 ? {8{store_data_i[7:0]}} :
              funct3_i[1:0] == 2'd1 ? {4{store_data_i[15:0]}} :
              funct3_i[1:0] == 2'd2 ? {2{store_data_i[31:0]}} : store_data_i;
    lane    = dmem_rdata_i >> {cap_wdata[2:0], 3'b000};
    // funct3[2] selects zero extension
    ld_data = cap_f3[1:0] == 2'd0 ? {{56{~cap_f3[2] & lane[7]}}, lane[7:0]} :
              cap_f3[1:0] == 2'd1 ? {{48{~cap_f3[2] & lane[15]}}, lane[15:0]} :
              cap_f3[1:0] == 2'd2 ? {{32{~cap_f3[2] & lane[31]}}, lane[31:0]} : lane;
    tmo     = TO != 32'd0 && cnt >= TO - 32'd1;
    done_st = state == REQ & dmem_gnt_i & ~cap_load;
    done_ld = state == WAIT & dmem_rvalid_i;
    // a grant or rvalid arriving on the last allowed cycle still wins over the timeout
    abort   = state != IDLE & tmo & ~(state == REQ & dmem_gnt_i) & ~done_ld;
    fin     = done_st | done_ld | abort;
    state_nx = state == IDLE ? ((acc & is_mem & ~misal) ? REQ : IDLE) :
               fin ? IDLE : (state == REQ & dmem_gnt_i) ? WAIT : state;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      {cap_load, cap_wreg, cap_csr_wreg, cap_f3, cap_rd, cap_csr_waddr, cap_wdata, cap_csr_wdata} <= '0;
      {dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wmask_o} <= '0;
      {wb_valid_o, wb_rd_addr_o, wb_wreg_o, wb_wdata_o} <= '0;
      {wb_csr_waddr_o, wb_csr_wreg_o, wb_csr_wdata_o} <= '0;
      {misalign_o, bus_err_o} <= '0;
    end else begin
      state <= state_nx;
      cnt <= state == IDLE ? 32'd0 : cnt + 32'd1;
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o <= 1'b0;
      if (acc) begin
        cap_load <= is_ld;
        cap_wreg <= wreg_i & |rd_addr_i;
        cap_f3 <= funct3_i;
        cap_rd <= rd_addr_i;
        cap_wdata <= wdata_i;
        cap_csr_waddr <= csr_waddr_i;
        cap_csr_wreg <= csr_wreg_i;
        cap_csr_wdata <= csr_wdata_i;
        dmem_addr_o <= {wdata_i[63:3], 3'b000};
        dmem_we_o <= is_st;
        dmem_wdata_o <= st_rep;
        dmem_wmask_o <= is_st ? sz_mask << wdata_i[2:0] : 8'h00;
        if (!is_mem || misal) begin
          wb_valid_o <= 1'b1;
          wb_rd_addr_o <= rd_addr_i;
          wb_wreg_o <= wreg_i & |rd_addr_i & ~is_mem;
          wb_wdata_o <= wdata_i;
          wb_csr_waddr_o <= csr_waddr_i;
          wb_csr_wreg_o <= csr_wreg_i;
          wb_csr_wdata_o <= csr_wdata_i;
          misalign_o <= is_mem;
        end
      end
      if (fin) begin
        wb_valid_o <= 1'b1;
        wb_rd_addr_o <= cap_rd;
        wb_wreg_o <= done_ld & cap_wreg;
        wb_wdata_o <= done_ld ? ld_data : cap_wdata;
        wb_csr_waddr_o <= cap_csr_waddr;
        wb_csr_wreg_o <= cap_csr_wreg;
        wb_csr_wdata_o <= cap_csr_wdata;
        bus_err_o <= abort;
      end
    end
  end
  assign ex_ready_o           = state == IDLE;
  assign stall_req_o          = state != IDLE;
  assign dmem_req_o           = state == REQ;
  assign mem_back_rd_addr_o   = wb_rd_addr_o;
  assign mem_back_wreg_o      = wb_valid_o & wb_wreg_o;
  assign mem_back_wdata_o     = wb_wdata_o;
  assign mem_back_csr_waddr_o = wb_csr_waddr_o;
  assign mem_back_csr_wreg_o  = wb_valid_o & wb_csr_wreg_o;
  assign mem_back_csr_wdata_o = wb_csr_wdata_o;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed checks of the memory access stage with a short bus timeout.
module tb_mem_access_stage;
  logic clk = 1'b0, rst = 1'b0;
  logic ex_valid_i = 1'b0, wreg_i = 1'b0, csr_wreg_i = 1'b0;
  logic [6:0] opcode_i = '0;
  logic [2:0] funct3_i = '0;
  logic [4:0] rd_addr_i = '0;
  logic [63:0] wdata_i = '0, store_data_i = '0, csr_wdata_i = '0, dmem_rdata_i = '0;
  logic [11:0] csr_waddr_i = '0;
  logic dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic ex_ready_o, dmem_req_o, dmem_we_o, wb_valid_o, wb_wreg_o, wb_csr_wreg_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, wb_wdata_o, wb_csr_wdata_o, mem_back_wdata_o, mem_back_csr_wdata_o;
  logic [7:0] dmem_wmask_o;
  logic [4:0] wb_rd_addr_o, mem_back_rd_addr_o;
  logic [11:0] wb_csr_waddr_o, mem_back_csr_waddr_o;
  logic mem_back_wreg_o, mem_back_csr_wreg_o, stall_req_o, misalign_o, bus_err_o;
  int checks = 0, errors = 0, n;
  localparam logic [6:0] ADD = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_addr_i(rd_addr_i), .wreg_i(wreg_i),
    .wdata_i(wdata_i), .store_data_i(store_data_i), .csr_waddr_i(csr_waddr_i),
    .csr_wreg_i(csr_wreg_i), .csr_wdata_i(csr_wdata_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_wmask_o(dmem_wmask_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_rd_addr_o(wb_rd_addr_o),
    .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o), .wb_csr_waddr_o(wb_csr_waddr_o),
    .wb_csr_wreg_o(wb_csr_wreg_o), .wb_csr_wdata_o(wb_csr_wdata_o),
    .mem_back_rd_addr_o(mem_back_rd_addr_o), .mem_back_wreg_o(mem_back_wreg_o),
    .mem_back_wdata_o(mem_back_wdata_o), .mem_back_csr_waddr_o(mem_back_csr_waddr_o),
    .mem_back_csr_wreg_o(mem_back_csr_wreg_o), .mem_back_csr_wdata_o(mem_back_csr_wdata_o),
    .stall_req_o(stall_req_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [63:0] ea,
                       input logic [63:0] sd, input logic [4:0] rd, input logic wr);
    opcode_i = op; funct3_i = f3; wdata_i = ea; store_data_i = sd; rd_addr_i = rd; wreg_i = wr;
    ex_valid_i = 1'b1;
    step;
    ex_valid_i = 1'b0;
  endtask

  task automatic load(input string tag, input logic [2:0] f3, input logic [63:0] ea,
                      input logic [63:0] rdata, input logic [63:0] exp);
    issue(LD, f3, ea, 64'd0, 5'd5, 1'b1);
    check({tag, " req"}, {63'd0, dmem_req_o}, 64'd1);
    check({tag, " addr"}, dmem_addr_o, {ea[63:3], 3'b000});
    check({tag, " we/mask"}, {55'd0, dmem_we_o, dmem_wmask_o}, 64'd0);
    dmem_gnt_i = 1'b1;
    step;
    dmem_gnt_i = 1'b0;
    check({tag, " wait"}, {62'd0, dmem_req_o, stall_req_o}, 64'd1);
    step;
    dmem_rdata_i = rdata; dmem_rvalid_i = 1'b1;
    step;
    dmem_rvalid_i = 1'b0;
    check({tag, " valid/wreg/ready"}, {61'd0, wb_valid_o, wb_wreg_o, ex_ready_o}, 64'd7);
    check({tag, " data"}, wb_wdata_o, exp);
    check({tag, " csr"}, {52'd0, wb_csr_waddr_o}, 64'h300);
  endtask

  initial begin
    csr_waddr_i = 12'h300; csr_wreg_i = 1'b1; csr_wdata_i = 64'hCAFE;
    #12;
    check("reset ready/stall", {62'd0, ex_ready_o, stall_req_o}, 64'd2);
    check("reset dmem", {dmem_req_o, dmem_we_o, dmem_wmask_o} | dmem_addr_o | dmem_wdata_o, 64'd0);
    check("reset wb", {wb_valid_o, wb_wreg_o, misalign_o, bus_err_o} | wb_wdata_o, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    // ADD with CSR write riding along
    issue(ADD, 3'd0, 64'h5, 64'd0, 5'd3, 1'b1);
    check("add valid", {63'd0, wb_valid_o}, 64'd1);
    check("add data", wb_wdata_o, 64'h5);
    check("add fwd", {57'd0, mem_back_rd_addr_o, mem_back_wreg_o, mem_back_csr_wreg_o}, {57'd0, 5'd3, 2'b11});
    check("add csr", mem_back_csr_wdata_o, 64'hCAFE);
    // back-to-back, second targets x0
    issue(ADD, 3'd0, 64'h7, 64'd0, 5'd4, 1'b1);
    check("b2b1", {wb_valid_o, wb_wreg_o} | wb_wdata_o, 64'h7 | 64'd3);
    issue(ADD, 3'd0, 64'h9, 64'd0, 5'd0, 1'b1);
    check("b2b2 x0", {62'd0, wb_valid_o, mem_back_wreg_o}, 64'd2);
    check("b2b2 data", wb_wdata_o, 64'h9);
    step;
    check("pulse end", {63'd0, wb_valid_o}, 64'd0);
    load("lb", 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    load("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h80);
    load("lh", 3'b001, 64'h1006, 64'h9234_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9234);
    load("lwu", 3'b110, 64'h1004, 64'h8765_4321_0000_0000, 64'h8765_4321);
    // sh with grant held off three cycles
    issue(ST, 3'b001, 64'h2006, 64'hBEEF, 5'd6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("sh req/we", {61'd0, dmem_req_o, dmem_we_o, wb_valid_o}, 64'd6);
      check("sh addr", dmem_addr_o, 64'h2000);
      check("sh mask", {56'd0, dmem_wmask_o}, 64'hC0);
      check("sh wdata", dmem_wdata_o, 64'hBEEF_BEEF_BEEF_BEEF);
      step;
    end
    dmem_gnt_i = 1'b1;
    check("sh req at gnt", {63'd0, dmem_req_o}, 64'd1);
    step;
    dmem_gnt_i = 1'b0;
    check("sh done", {60'd0, wb_valid_o, wb_wreg_o, dmem_req_o, ex_ready_o}, 64'b1001);
    // misaligned lw
    issue(LD, 3'b010, 64'h1002, 64'd0, 5'd7, 1'b1);
    check("lw misalign", {59'd0, dmem_req_o, misalign_o, wb_valid_o, wb_wreg_o, ex_ready_o}, 64'b01101);
    step;
    check("misalign pulse", {62'd0, misalign_o, wb_valid_o}, 64'd0);
    // ld never granted
    issue(LD, 3'b011, 64'h3000, 64'd0, 5'd8, 1'b1);
    n = 0;
    for (int i = 0; i < 20 && dmem_req_o; i++) begin
      n++;
      step;
    end
    check("timeout req cycles", 64'(n), 64'd4);
    check("timeout err", {59'd0, dmem_req_o, bus_err_o, wb_valid_o, wb_wreg_o, ex_ready_o}, 64'b01101);
    step;
    check("err pulse", {63'd0, bus_err_o}, 64'd0);
    // async reset while waiting for load data
    issue(LD, 3'b011, 64'h1008, 64'd0, 5'd9, 1'b1);
    dmem_gnt_i = 1'b1;
    step;
    dmem_gnt_i = 1'b0;
    check("pre-rst stall", {63'd0, stall_req_o}, 64'd1);
    rst = 1'b0;
    #1;
    check("rst ctl", {61'd0, stall_req_o, dmem_req_o, ex_ready_o}, 64'd1);
    check("rst wb", {wb_valid_o, wb_wreg_o, dmem_we_o, dmem_wmask_o} | wb_wdata_o | dmem_addr_o, 64'd0);
    step;
    rst = 1'b1;
    dmem_rdata_i = 64'h1111; dmem_rvalid_i = 1'b1;
    step;
    dmem_rvalid_i = 1'b0;
    check("stale rvalid", {62'd0, wb_valid_o, ex_ready_o}, 64'd1);
    issue(ADD, 3'd0, 64'h1234, 64'd0, 5'd7, 1'b1);
    check("post-rst add", {wb_valid_o, mem_back_wreg_o} | wb_wdata_o, 64'h1234 | 64'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
